// File: rtl/window_gen_3x3_if.sv
// Stream bundle for window_gen_3x3: raster RGB pixels in, 3x3 RGB windows out.
// slave is the window generator's view; master is the source/consumer side.
interface window_gen_3x3_if;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_r;
    logic [71:0] win_g;
    logic [71:0] win_b;
    logic        win_last;

    modport slave (
        input  pix_valid, pix_sof, pix_r, pix_g, pix_b, win_ready,
        output pix_ready, win_valid, win_r, win_g, win_b, win_last
    );

    modport master (
        output pix_valid, pix_sof, pix_r, pix_g, pix_b, win_ready,
        input  pix_ready, win_valid, win_r, win_g, win_b, win_last
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster-order RGB to 3x3 sliding-window generator built from two line buffers.
// Defining WINGEN_WIN_COUNT_EN adds a saturating per-frame window counter output.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic            clk,
    input  logic            reset,
`ifdef WINGEN_WIN_COUNT_EN
    output logic [15:0]     win_count,
`endif
    window_gen_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [CW-1:0] col_next;
    logic [CW-1:0] pos_col;
    logic [RW-1:0] row;
    logic [RW-1:0] row_next;
    logic [RW-1:0] pos_row;
    logic          accept;
    logic          take;
    logic          produce;
    logic          at_end;
    logic          transfer;

    logic [23:0]   line_prev  [IMG_WIDTH];
    logic [23:0]   line_prev2 [IMG_WIDTH];
    logic [23:0]   pixel;
    logic [23:0]   tap_top;
    logic [23:0]   tap_mid;

    logic [71:0]   win_r;
    logic [71:0]   win_g;
    logic [71:0]   win_b;
    logic          win_valid;
    logic          win_last;

    assign transfer      = win_valid && bus.win_ready;
    assign bus.pix_ready = !reset && (!win_valid || bus.win_ready);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign pixel         = {bus.pix_r, bus.pix_g, bus.pix_b};

    assign bus.win_valid = win_valid;
    assign bus.win_last  = win_last;
    assign bus.win_r     = win_r;
    assign bus.win_g     = win_g;
    assign bus.win_b     = win_b;

    // Drops the oldest column (a,d,g) and appends the new column on the right (c,f,i).
    function automatic logic [71:0] shift_in(input logic [71:0] w, input logic [7:0] top,
                                             input logic [7:0] mid, input logic [7:0] bot);
        return {bot, w[71:64], w[63:56], mid, w[47:40], w[39:32], top, w[23:16], w[15:8]};
    endfunction

    always_comb begin
        state_next = state;
        pos_col    = col;
        pos_row    = row;
        col_next   = col;
        row_next   = row;
        take       = 1'b0;
        produce    = 1'b0;
        at_end     = 1'b0;
        if (accept && bus.pix_sof) begin
            pos_col = '0;
            pos_row = '0;
        end
        if (accept && (bus.pix_sof || state != IDLE)) begin
            take    = 1'b1;
            at_end  = (pos_col == LAST_COL) && (pos_row == LAST_ROW);
            produce = (pos_col >= CW'(2)) && (pos_row >= RW'(2));
            if (pos_col == LAST_COL) begin
                col_next = '0;
                row_next = pos_row + RW'(1);
            end else begin
                col_next = pos_col + CW'(1);
                row_next = pos_row;
            end
            if (bus.pix_sof) begin
                state_next = FILL;
            end else if (state == FILL && pos_row == RW'(2) && pos_col == '0) begin
                state_next = STREAM;
            end else if (state == STREAM && at_end) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign tap_top = line_prev2[pos_col];
    assign tap_mid = line_prev[pos_col];

    // Line storage has no reset: rows are always rewritten before a window uses them.
    always_ff @(posedge clk) begin
        if (take) begin
            line_prev2[pos_col] <= line_prev[pos_col];
            line_prev[pos_col]  <= pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_r     <= '0;
            win_g     <= '0;
            win_b     <= '0;
        end else begin
            col <= col_next;
            row <= row_next;
            if (take) begin
                win_r <= shift_in(win_r, tap_top[23:16], tap_mid[23:16], pixel[23:16]);
                win_g <= shift_in(win_g, tap_top[15:8],  tap_mid[15:8],  pixel[15:8]);
                win_b <= shift_in(win_b, tap_top[7:0],   tap_mid[7:0],   pixel[7:0]);
            end
            if (produce) begin
                win_valid <= 1'b1;
                win_last  <= at_end;
            end else if (transfer) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

`ifdef WINGEN_WIN_COUNT_EN
    // A new frame start wins over a coincident transfer of the previous frame's last window.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_count <= '0;
        end else if (accept && bus.pix_sof) begin
            win_count <= '0;
        end else if (transfer && win_count != 16'hFFFF) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 frame; expected windows come from a frame-image model.
module tb_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 4;
    localparam logic [71:0] G_OFS = 72'h101010101010101010;
    localparam logic [71:0] B_OFS = 72'h202020202020202020;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_gen_3x3_if bus ();
`ifdef WINGEN_WIN_COUNT_EN
    logic [15:0] win_count;
`endif

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk),
        .reset(reset),
`ifdef WINGEN_WIN_COUNT_EN
        .win_count(win_count),
`endif
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int dut_windows = 0;

    logic [23:0] img [H][W];
    int          m_row;
    int          m_col;
    bit          m_active;
    bit          m_wv;
    bit          m_last;
    logic [71:0] m_r;
    logic [71:0] m_g;
    logic [71:0] m_b;
    int          m_count;

    typedef struct {
        bit          valid;
        bit          sof;
        int          n;
        bit          ready;
        bit          exp_wv;
        bit          exp_last;
        logic [71:0] exp_r;
    } vec_t;

    vec_t vecs[18];

    task automatic check_output(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic logic [23:0] pix_of(input int n);
        return {8'(n), 8'(n + 16), 8'(n + 32)};
    endfunction

    task automatic apply_stimulus(input bit v, input bit sof, input logic [23:0] pix, input bit rdy);
        bus.pix_valid = v;
        bus.pix_sof   = sof;
        bus.pix_r     = pix[23:16];
        bus.pix_g     = pix[15:8];
        bus.pix_b     = pix[7:0];
        bus.win_ready = rdy;
    endtask

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        m_active = 1'b0;
        m_wv = 1'b0;
        m_last = 1'b0;
        m_r = '0;
        m_g = '0;
        m_b = '0;
        m_count = 0;
    endtask

    // Frame model: store each accepted pixel at its (row,col) and cut the 3x3 neighbourhood out of the image.
    task automatic model_update(input bit acc, input bit sof, input logic [23:0] pix, input bit xfer);
        logic [23:0] p;
        if (xfer) begin
            m_wv = 1'b0;
            m_last = 1'b0;
            if (m_count < 65535) m_count++;
        end
        if (acc && (sof || m_active)) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
                m_active = 1'b1;
                m_count = 0;
            end
            img[m_row][m_col] = pix;
            if (m_row >= 2 && m_col >= 2) begin
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        p = img[m_row - 2 + dr][m_col - 2 + dc];
                        m_r[(dr * 3 + dc) * 8 +: 8] = p[23:16];
                        m_g[(dr * 3 + dc) * 8 +: 8] = p[15:8];
                        m_b[(dr * 3 + dc) * 8 +: 8] = p[7:0];
                    end
                end
                m_wv = 1'b1;
                m_last = (m_row == H - 1) && (m_col == W - 1);
            end
            if (m_row == H - 1 && m_col == W - 1) m_active = 1'b0;
            if (m_col == W - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic model_cycle(input bit v, input bit sof, input logic [23:0] pix, input bit rdy,
                               output bit accepted);
        bit exp_ready;
        bit xfer;
        apply_stimulus(v, sof, pix, rdy);
        #1;
        exp_ready = !m_wv || rdy;
        check_output("pix_ready", 72'(bus.pix_ready), 72'(exp_ready));
        accepted = v && exp_ready;
        xfer = m_wv && rdy;
        if (bus.win_valid && rdy) dut_windows++;
        model_update(accepted, sof, pix, xfer);
        @(posedge clk);
        @(negedge clk);
        check_output("win_valid", 72'(bus.win_valid), 72'(m_wv));
        check_output("win_last", 72'(bus.win_last), 72'(m_last));
        if (m_wv) begin
            check_output("win_r", bus.win_r, m_r);
            check_output("win_g", bus.win_g, m_g);
            check_output("win_b", bus.win_b, m_b);
        end
`ifdef WINGEN_WIN_COUNT_EN
        check_output("win_count", 72'(win_count), 72'(m_count));
`endif
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) model_cycle(1'b0, 1'b0, 24'h0, 1'b1, acc);
    endtask

    task automatic send_pixels(input int first_n, input int count, input bit with_sof, input int stall_len);
        int k = 0;
        int stall = stall_len;
        int budget = count * 4 + stall_len + 20;
        bit acc;
        bit rdy;
        while (k < count && budget > 0) begin
            rdy = 1'b1;
            if (m_wv && stall > 0) begin
                rdy = 1'b0;
                stall--;
            end
            model_cycle(1'b1, with_sof && k == 0, pix_of(first_n + k), rdy, acc);
            if (acc) k++;
            budget--;
        end
        check_output("pixels_accepted", 72'(k), 72'(count));
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 24'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("rst_pix_ready", 72'(bus.pix_ready), 72'(0));
        check_output("rst_win_valid", 72'(bus.win_valid), 72'(0));
        check_output("rst_win_last", 72'(bus.win_last), 72'(0));
        check_output("rst_win_r", bus.win_r, 72'(0));
        check_output("rst_win_g", bus.win_g, 72'(0));
        check_output("rst_win_b", bus.win_b, 72'(0));
`ifdef WINGEN_WIN_COUNT_EN
        check_output("rst_win_count", 72'(win_count), 72'(0));
`endif
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
        model_reset();
        @(negedge clk);

        // Reference frame n = row*4+col with fixed expected windows.
        for (int i = 0; i < 18; i++) begin
            vecs[i] = '{valid: (i < 16), sof: (i == 0), n: i, ready: 1'b1,
                        exp_wv: 1'b0, exp_last: 1'b0, exp_r: 72'h0};
        end
        vecs[10].exp_wv = 1'b1; vecs[10].exp_r = 72'h0A0908_060504_020100;
        vecs[11].exp_wv = 1'b1; vecs[11].exp_r = 72'h0B0A09_070605_030201;
        vecs[14].exp_wv = 1'b1; vecs[14].exp_r = 72'h0E0D0C_0A0908_060504;
        vecs[15].exp_wv = 1'b1; vecs[15].exp_r = 72'h0F0E0D_0B0A09_070605;
        vecs[15].exp_last = 1'b1;

        do_reset();
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].sof, pix_of(vecs[i].n), vecs[i].ready);
            @(posedge clk);
            @(negedge clk);
            check_output("tbl_win_valid", 72'(bus.win_valid), 72'(vecs[i].exp_wv));
            check_output("tbl_win_last", 72'(bus.win_last), 72'(vecs[i].exp_last));
            if (vecs[i].exp_wv) begin
                check_output("tbl_win_r", bus.win_r, vecs[i].exp_r);
                check_output("tbl_win_g", bus.win_g, vecs[i].exp_r + G_OFS);
                check_output("tbl_win_b", bus.win_b, vecs[i].exp_r + B_OFS);
            end
        end

        // Consumer stalls five cycles on the first window.
        do_reset();
        dut_windows = 0;
        send_pixels(0, 16, 1'b1, 5);
        idle(3);
        check_output("stall_windows", 72'(dut_windows), 72'(4));

        // Pixels without a frame start are discarded, then a proper frame.
        do_reset();
        dut_windows = 0;
        send_pixels(0, 16, 1'b0, 0);
        idle(2);
        check_output("nosof_windows", 72'(dut_windows), 72'(0));
        send_pixels(0, 16, 1'b1, 0);
        idle(3);
        check_output("sof_after_junk_windows", 72'(dut_windows), 72'(4));

        // Frame restart at pixel 9, and again while a window is pending.
        do_reset();
        dut_windows = 0;
        send_pixels(0, 9, 1'b1, 0);
        send_pixels(9, 16, 1'b1, 0);
        idle(3);
        check_output("restart9_windows", 72'(dut_windows), 72'(4));
        do_reset();
        dut_windows = 0;
        send_pixels(0, 11, 1'b1, 0);
        send_pixels(11, 16, 1'b1, 0);
        idle(3);
        check_output("restart11_windows", 72'(dut_windows), 72'(5));

        // Reset while a window waits for the consumer; the next frame needs a new start.
        do_reset();
        send_pixels(0, 11, 1'b1, 0);
        check_output("pre_reset_win_valid", 72'(bus.win_valid), 72'(m_wv));
        do_reset();
        dut_windows = 0;
        send_pixels(11, 5, 1'b0, 0);
        idle(2);
        check_output("post_reset_windows", 72'(dut_windows), 72'(0));

        // Three back-to-back frames, window count checked at each frame end.
        do_reset();
        dut_windows = 0;
        for (int f = 0; f < 3; f++) begin
            send_pixels(f * 16, 16, 1'b1, 0);
            idle(2);
`ifdef WINGEN_WIN_COUNT_EN
            check_output("frame_win_count", 72'(win_count), 72'(4));
`endif
        end
        check_output("three_frame_windows", 72'(dut_windows), 72'(12));

        // Random traffic, stalls and occasional restarts against the image model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            model_cycle($urandom_range(0, 3) != 0,
                        (c == 0) || ($urandom_range(0, 39) == 0),
                        24'($urandom),
                        $urandom_range(0, 9) < 7,
                        acc);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
